mux_nx1_stream: RTL and testbench

- Parametrised N-channel, W-bit-wide multiplexer with a registered output stage and a valid/ready handshake.
- Successor to the fixed 8:1 single-bit gate-level mux. Adds:
  - Manual-select or auto-scan (round-robin) channel sequencing.
  - Backpressure.
  - Channel tagging on the output.
- Sits between parallel sample sources and a single serial consumer, e.g. a scanner feeding a display or UART path.

---
 rtl/mux_stream_pkg.sv | 13 +
 rtl/mux_nx1_comb.sv | 40 ++++
 rtl/mux_nx1_stream.sv | 123 ++++++++++++
 tb/tb_mux_nx1_stream.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
// rtl/mux_stream_pkg.sv - shared FSM state type and mode constants for mux_nx1_stream
package mux_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nx1_comb.sv
// rtl/mux_nx1_comb.sv - combinational N_CH:1 selector of DW-bit channels, tree of 2:1 stages
module mux_nx1_comb #(
  parameter  int N_CH  = 8,
  parameter  int DW    = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH*DW-1:0] data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [DW-1:0]      data_o
);

  // Leaves are padded to a power of two; padding leaves read as zero so
  // out-of-range indices select 0.
  localparam int N_LEAF = 1 << SEL_W;

  logic [DW-1:0] leaf [N_LEAF];

  for (genvar k = 0; k < N_LEAF; k++) begin : g_leaf
    if (k < N_CH) begin : g_real
      assign leaf[k] = data_i[k*DW +: DW];
    end else begin : g_pad
      assign leaf[k] = '0;
    end
  end

  // Reduce level by level: stage d pairs adjacent nodes and picks one with sel bit d.
  always_comb begin
    logic [DW-1:0] lvl [N_LEAF];
    for (int k = 0; k < N_LEAF; k++) begin
      lvl[k] = leaf[k];
    end
    for (int d = 0; d < SEL_W; d++) begin
      for (int j = 0; j < (N_LEAF >> (d + 1)); j++) begin
        lvl[j] = sel_i[d] ? lvl[2*j+1] : lvl[2*j];
      end
    end
    data_o = lvl[0];
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// rtl/mux_nx1_stream.sv - N-channel registered stream mux with scan/manual select; option MUX_STREAM_PARITY_EN adds out_par
module mux_nx1_stream
  import mux_stream_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int DW    = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic               sel_load,
  input  logic [N_CH*DW-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [SEL_W-1:0]   out_ch
`ifdef MUX_STREAM_PARITY_EN
  ,
  output logic               out_par
`endif
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [DW-1:0]    sel_data;
  logic             capture;

  mux_nx1_comb #(
    .N_CH (N_CH),
    .DW   (DW)
  ) u_sel (
    .data_i (data_in),
    .sel_i  (ptr_q),
    .data_o (sel_data)
  );

  // Handshake FSM: decide whether this edge captures a new sample and where to go next.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN, STALL: begin
        if (out_ready) begin
          if (en) begin
            capture = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STALL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer names the channel of the next capture; a valid sel_load beats a scan advance.
  always_comb begin
    ptr_d = ptr_q;
    if (sel_load && (int'(sel_in) < N_CH)) begin
      ptr_d = sel_in;
    end else if (capture && (mode == MODE_SCAN)) begin
      ptr_d = (ptr_q == SEL_W'(N_CH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // Output stage loads only on capture, so held data stays frozen while stalled.
  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    if (capture) begin
      data_d = sel_data;
      ch_d   = ptr_q;
    end
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign out_valid = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

`ifdef MUX_STREAM_PARITY_EN
  logic par_q;

  // Parity bit registered alongside the sample it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (capture) begin
      par_q <= ^sel_data;
    end
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb/tb_mux_nx1_stream.sv - self-checking bench for mux_nx1_stream (N_CH=5/DW=8 and N_CH=8/DW=1)
module tb_mux_nx1_stream;

  logic        clk = 1'b0;
  logic        rst, en, mode, sel_load, out_ready;
  logic [2:0]  sel_in;
  logic [39:0] data_a;
  logic [7:0]  data_b;

  logic        a_valid, b_valid;
  logic [7:0]  a_data;
  logic [0:0]  b_data;
  logic [2:0]  a_ch, b_ch;
`ifdef MUX_STREAM_PARITY_EN
  logic        a_par, b_par;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  mux_nx1_stream #(.N_CH(5), .DW(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .sel_load(sel_load),
    .data_in(data_a), .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_ch(a_ch)
`ifdef MUX_STREAM_PARITY_EN
    , .out_par(a_par)
`endif
  );

  mux_nx1_stream #(.N_CH(8), .DW(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .sel_load(sel_load),
    .data_in(data_b), .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_ch(b_ch)
`ifdef MUX_STREAM_PARITY_EN
    , .out_par(b_par)
`endif
  );

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: index 0 is u_a, index 1 is u_b.
  int         n_ch [2] = '{5, 8};
  bit         m_valid [2];
  logic [7:0] m_data [2];
  int         m_ch [2];
  int         m_ptr [2];

  function automatic logic [7:0] chan(input int i, input int p);
    if (i == 0) return data_a[p*8 +: 8];
    return {7'b0, data_b[p]};
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_data[i] = '0; m_ch[i] = 0; m_ptr[i] = 0;
    end
  end

  always @(posedge clk) begin
    bit cap;
    int nxt;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_valid[i] <= 1'b0; m_data[i] <= '0; m_ch[i] <= 0; m_ptr[i] <= 0;
      end else begin
        cap = en && (!m_valid[i] || out_ready);
        nxt = m_ptr[i];
        if (sel_load && int'(sel_in) < n_ch[i]) nxt = int'(sel_in);
        else if (cap && mode) nxt = (m_ptr[i] + 1) % n_ch[i];
        if (cap) begin
          m_valid[i] <= 1'b1;
          m_ch[i]    <= m_ptr[i];
          m_data[i]  <= chan(i, m_ptr[i]);
        end else if (m_valid[i] && out_ready) begin
          m_valid[i] <= 1'b0;
        end
        m_ptr[i] <= nxt;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("m_a_valid", a_valid, m_valid[0]);
      chk("m_b_valid", b_valid, m_valid[1]);
      if (m_valid[0]) begin
        chk("m_a_data", a_data, m_data[0]);
        chk("m_a_ch", a_ch, m_ch[0]);
`ifdef MUX_STREAM_PARITY_EN
        chk("m_a_par", a_par, ^m_data[0]);
`endif
      end
      if (m_valid[1]) begin
        chk("m_b_data", b_data, m_data[1]);
        chk("m_b_ch", b_ch, m_ch[1]);
`ifdef MUX_STREAM_PARITY_EN
        chk("m_b_par", b_par, ^m_data[1]);
`endif
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_in = '0; sel_load = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) data_a[k*8 +: 8] = 8'(k + 3);
    data_b = 8'h01;

    // Reset held two cycles, then capture channel 0.
    tick(); checking = 1'b1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    tick();
    chk("rst2_b_valid", b_valid, 0);
    rst = 1'b0; en = 1'b1;
    tick();
    chk("cap_b_valid", b_valid, 1);
    chk("cap_b_data", b_data, 1);
    chk("cap_b_ch", b_ch, 0);
    chk("cap_a_data", a_data, 3);

    // Auto-scan with wrap on the 5-channel instance.
    rst = 1'b1; tick(); rst = 1'b0; mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("scan_a_valid", a_valid, 1);
      chk("scan_a_ch", a_ch, i % 5);
      chk("scan_a_data", a_data, (i % 5) + 3);
    end

    // Backpressure: outputs frozen while data_in churns.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_a = 40'({$urandom(), $urandom()});
      tick();
      chk("stall_a_ch", a_ch, 1);
      chk("stall_a_data", a_data, 4);
    end
    for (int k = 0; k < 5; k++) data_a[k*8 +: 8] = 8'(8'h50 + k);
    out_ready = 1'b1;
    tick();
    chk("unstall_a_ch", a_ch, 2);
    chk("unstall_a_data", a_data, 8'h52);

    // Manual select, then an out-of-range load on the 5-channel instance.
    mode = 1'b0; sel_in = 3'd4; sel_load = 1'b1;
    tick(); sel_load = 1'b0;
    chk("man_a_ch0", a_ch, 3);
    tick();
    chk("man_a_ch1", a_ch, 4);
    tick();
    chk("man_a_hold", a_ch, 4);
    sel_in = 3'd6; sel_load = 1'b1;
    tick(); sel_load = 1'b0;
    tick();
    chk("oor_a_ch", a_ch, 4);
    chk("sel6_b_ch", b_ch, 6);

    // sel_load in the same cycle as a scan transfer.
    mode = 1'b1; sel_in = 3'd2; sel_load = 1'b1;
    tick(); sel_load = 1'b0;
    chk("coll_a_ch0", a_ch, 4);
    tick();
    chk("coll_a_ch1", a_ch, 2);
    chk("coll_b_ch1", b_ch, 2);

    // Reset arriving while stalled.
    out_ready = 1'b0;
    tick();
    chk("mstall_a_valid", a_valid, 1);
    rst = 1'b1;
    tick();
    chk("mrst_a_valid", a_valid, 0);
    chk("mrst_a_ch", a_ch, 0);
    chk("mrst_a_data", a_data, 0);
    chk("mrst_b_valid", b_valid, 0);
    chk("mrst_b_data", b_data, 0);
    rst = 1'b0; out_ready = 1'b1; mode = 1'b0;

`ifdef MUX_STREAM_PARITY_EN
    data_a[7:0] = 8'hA7;
    tick();
    chk("par_a7", a_par, 1);
    data_a[7:0] = 8'hA6;
    tick();
    chk("par_a6", a_par, 0);
`endif

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel_in    = 3'($urandom_range(0, 7));
      sel_load  = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      data_a    = 40'({$urandom(), $urandom()});
      data_b    = 8'($urandom());
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
